// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and a constant-foldable ceil(log2) for sizing the bit counter.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Never returns less than 1 so a counter vector is always legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: D = A - B - Bi, Bo is the borrow out.
module full_subtractor (
    output logic D,
    output logic Bo,
    input  logic A,
    input  logic B,
    input  logic Bi
);

    assign D  = A ^ B ^ Bi;
    assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (Diff = X - Y - Bin), one bit per clock, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to register a signed-overflow flag alongside Diff.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             ovf
);

    localparam int CNT_W = clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_xs;
    logic [WIDTH-1:0]   r_ys;
    logic [WIDTH-2:0]   r_partial;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_d;
    logic               w_bo;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH-1:0]   w_result;

    full_subtractor u_fs (
        .D  (w_d),
        .Bo (w_bo),
        .A  (r_xs[0]),
        .B  (r_ys[0]),
        .Bi (r_borrow)
    );

    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; on the final bit this is the complete difference.
    assign w_result = {w_d, r_partial};

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_xs      <= '0;
            r_ys      <= '0;
            r_partial <= '0;
            r_borrow  <= 1'b0;
            r_cnt     <= '0;
            Diff      <= '0;
            Bout      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_xs      <= X;
                r_ys      <= Y;
                r_borrow  <= Bin;
                r_cnt     <= '0;
                r_partial <= '0;
            end else if (r_state == S_SHIFT) begin
                r_xs      <= r_xs >> 1;
                r_ys      <= r_ys >> 1;
                r_borrow  <= w_bo;
                r_partial <= w_result[WIDTH-1:1];
                r_cnt     <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    Diff <= w_result;
                    Bout <= w_bo;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_ovf;

    // Borrow into the MSB differing from borrow out of it marks signed overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_SHIFT && w_last && !w_accept) begin
            r_ovf <= r_borrow ^ w_bo;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a driver issues operations and queues
// expected results from an arithmetic model; a negedge monitor checks outputs.
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        int           x;
        int           y;
        int           b;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           checks = 0;
    int           errors = 0;
    exp_t         sb_q[$];
    logic [W-1:0] hold_diff = '0;
    logic         hold_bout = 1'b0;
    logic         hold_ovf  = 1'b0;
    logic         mon_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input int x, input int y, input int b, input int dc);
        exp_t e;
        int d, sx, sy, sd;
        d          = x - y - b;
        e.x        = x;
        e.y        = y;
        e.b        = b;
        e.diff     = W'((d + (1 << W)) % (1 << W));
        e.bout     = (d < 0);
        e.done_cyc = dc;
`ifdef SERIAL_SUB_OVERFLOW_EN
        sx    = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy    = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        sd    = sx - sy - b;
        e.ovf = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
`else
        sx    = 0;
        sy    = 0;
        sd    = 0;
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_done;
        logic exp_busy;
        if (rst_n && mon_en) begin
            exp_done = (sb_q.size() > 0) && (cyc == sb_q[0].done_cyc);
            exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].done_cyc - W) && (cyc < sb_q[0].done_cyc);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_done) begin
                e = sb_q.pop_front();
                chk("diff", 32'(Diff), 32'(e.diff));
                chk("bout", 32'(Bout), 32'(e.bout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                hold_diff = e.diff;
                hold_bout = e.bout;
                hold_ovf  = e.ovf;
                $display("op x=%0d y=%0d bin=%0d -> diff=%0d bout=%0d ovf=%0d (exp %0d %0d %0d) cyc=%0d",
                         e.x, e.y, e.b, Diff, Bout, ovf, e.diff, e.bout, e.ovf, cyc);
            end else begin
                chk("diff_hold", 32'(Diff), 32'(hold_diff));
                chk("bout_hold", 32'(Bout), 32'(hold_bout));
                chk("ovf_hold", 32'(ovf), 32'(hold_ovf));
            end
        end
    end

    task automatic issue(input int x, input int y, input int b, input bit hold, input int gap);
        int t;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        t = 0;
        while (busy === 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle cyc=%0d", cyc);
        end
        X     = W'(x);
        Y     = W'(y);
        Bin   = b[0];
        start = 1'b1;
        sb_q.push_back(model(x, y, b, cyc + 1 + W));
        @(posedge clk);
        #1;
        if (hold) begin
            for (int i = 0; i < W - 1; i++) begin
                start = 1'b1;
                X     = W'($urandom);
                Y     = W'($urandom);
                Bin   = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        X     = W'($urandom);
        Y     = W'($urandom);
        Bin   = 1'($urandom);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        X     = '0;
        Y     = '0;
        Bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(Diff), 32'd0);
        chk("rst_bout", 32'(Bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        mon_en = 1'b1;

        issue(9, 3, 0, 1'b0, 1);
        issue(3, 9, 0, 1'b0, 2);
        issue(0, 0, 1, 1'b0, 0);
        issue(8, 1, 0, 1'b0, 0);
        issue(5, 2, 1, 1'b1, 0);
        issue(15, 15, 1, 1'b0, 0);
        issue(7, 8, 0, 1'b0, 0);

        // Abort an operation with reset during its second busy cycle.
        issue(12, 5, 0, 1'b0, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        hold_diff = '0;
        hold_bout = 1'b0;
        hold_ovf  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(Diff), 32'd0);
        chk("abort_bout", 32'(Bout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        repeat (2 * W + 2) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end

        t = 0;
        while (sb_q.size() > 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
